// File: rtl/multiplier_control_unit.sv
// multiplier_control_unit: shift-add multiplier sequencer (START, WIDTH x ADD/SHIFT, DONE).
// Define MULT_CTRL_SYNC_EN to pass Run and Reset_Load_Clear through 2-flop synchronizers.
module multiplier_control_unit #(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Reset_Load_Clear,
    input  logic Run,
    input  logic M,
    output logic Ld_B,
    output logic Clr_XA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, START, ADD, SHIFT, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           rlc, run, last;

`ifdef MULT_CTRL_SYNC_EN
    logic [1:0] rlc_sync, run_sync;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rlc_sync <= '0;
            run_sync <= '0;
        end else begin
            rlc_sync <= {rlc_sync[0], Reset_Load_Clear};
            run_sync <= {run_sync[0], Run};
        end
    end

    assign rlc = rlc_sync[1];
    assign run = run_sync[1];
`else
    assign rlc = Reset_Load_Clear;
    assign run = Run;
`endif

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        Ld_B      = 1'b0;
        Clr_XA    = 1'b0;
        Add       = 1'b0;
        Sub       = 1'b0;
        Shift     = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                Ld_B   = rlc;
                Clr_XA = rlc;
                state_nxt = (!rlc && run) ? START : IDLE;
            end
            START: begin
                Clr_XA    = 1'b1;
                Busy      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ADD;
            end
            ADD: begin
                // the final partial product carries negative weight in two's complement
                Busy      = 1'b1;
                Add       = M && !last;
                Sub       = M && last;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                Busy      = 1'b1;
                Shift     = 1'b1;
                state_nxt = last ? DONE : ADD;
                cnt_nxt   = last ? cnt : cnt + CW'(1);
            end
            DONE: begin
                Done      = 1'b1;
                Ld_B      = rlc;
                Clr_XA    = rlc;
                state_nxt = run ? DONE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_multiplier_control_unit.sv
// tb_multiplier_control_unit: cycle-schedule model plus datapath model checked every cycle,
// with literal expectations for the directed multiplications.
module tb_multiplier_control_unit;
    localparam int W = 8;
    localparam logic [7:0] S = 8'h07;

    logic Clk = 1'b0, Reset_n = 1'b0, Reset_Load_Clear = 1'b0, Run = 1'b0, M;
    logic Ld_B, Clr_XA, Add, Sub, Shift, Busy, Done;

    int checks = 0, errors = 0;

    logic [7:0]  sw = 8'h00;
    logic [7:0]  bop = 8'h00;
    logic [8:0]  xa = 9'h000;
    logic [7:0]  b_r = 8'h00;
    int          mode = 0;
    int          c = 0;

    multiplier_control_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Reset_Load_Clear(Reset_Load_Clear), .Run(Run), .M(M),
        .Ld_B(Ld_B), .Clr_XA(Clr_XA), .Add(Add), .Sub(Sub), .Shift(Shift), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    assign M = b_r[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // mode 0 idle, 1 busy (c = cycle number within the sequence, 1..2W+1), 2 done
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mode = 0;
            c = 0;
        end else if (mode == 0) begin
            if (!Reset_Load_Clear && Run) begin
                mode = 1;
                c = 1;
            end
        end else if (mode == 1) begin
            c++;
            if (c > 2 * W + 1) mode = 2;
        end else if (!Run) begin
            mode = 0;
        end
    end

    always @(negedge Clk) begin
        automatic bit busy_e = (mode == 1);
        automatic bit add_cyc = busy_e && c >= 2 && c % 2 == 0;
        automatic int k = (c - 2) / 2;
        automatic bit bk = (add_cyc && k >= 0 && k < W) ? bop[k] : 1'b0;
        chk("ld_b", 32'(Ld_B), 32'(!busy_e && Reset_Load_Clear));
        chk("clr_xa", 32'(Clr_XA), 32'((busy_e && c == 1) || (!busy_e && Reset_Load_Clear)));
        chk("add", 32'(Add), 32'(bk && k < W - 1));
        chk("sub", 32'(Sub), 32'(bk && k == W - 1));
        chk("shift", 32'(Shift), 32'(busy_e && c >= 3 && c % 2 == 1));
        chk("busy", 32'(Busy), 32'(busy_e));
        chk("done", 32'(Done), 32'(mode == 2));
        if (Ld_B) b_r = sw;
        if (Clr_XA) xa = 9'h000;
        if (Add) xa = {xa[7], xa[7:0]} + {S[7], S};
        if (Sub) xa = {xa[7], xa[7:0]} - {S[7], S};
        if (Shift) {xa, b_r} = {xa[8], xa, b_r[7:1]};
    end

    task automatic load(input logic [7:0] v);
        @(posedge Clk);
        #2 sw = v; bop = v; Reset_Load_Clear = 1'b1;
        @(posedge Clk);
        #2 Reset_Load_Clear = 1'b0;
    endtask

    task automatic do_mult(input int hold, input bit poke, input logic [7:0] add_exp,
                           input logic [7:0] sub_exp, input logic [16:0] prod_exp);
        int done_cyc, shifts, stray;
        logic [7:0] addm, subm;
        done_cyc = 0; shifts = 0; stray = 0; addm = '0; subm = '0;
        @(posedge Clk);
        #2 Run = 1'b1;
        @(posedge Clk);
        for (int n = 1; n <= hold; n++) begin
            @(negedge Clk);
            #1;
            if (Done && done_cyc == 0) done_cyc = n;
            if (Shift) shifts++;
            if (Add && n >= 2 && n <= 2 * W) addm[(n - 2) / 2] = 1'b1;
            if (Sub && n >= 2 && n <= 2 * W) subm[(n - 2) / 2] = 1'b1;
            if (Ld_B || (Clr_XA && n != 1)) stray++;
            if (poke && n == 10) begin Reset_Load_Clear = 1'b1; Run = 1'b0; end
            if (poke && n == 11) begin Reset_Load_Clear = 1'b0; Run = 1'b1; end
        end
        chk("done_cycle", 32'(done_cyc), 32'd18);
        chk("shift_count", 32'(shifts), 32'd8);
        chk("add_iters", 32'(addm), 32'(add_exp));
        chk("sub_iters", 32'(subm), 32'(sub_exp));
        chk("stray_ld_clr", 32'(stray), 32'd0);
        chk("product", 32'({xa, b_r}), 32'(prod_exp));
        chk("done_held", 32'(Done), 32'd1);
        Run = 1'b0;
        @(negedge Clk);
        #1 chk("back_idle", 32'({Busy, Done}), 32'd0);
    endtask

    initial begin
        int lds;
        repeat (3) @(posedge Clk);
        #2 chk("rst_held", 32'({Ld_B, Clr_XA, Add, Sub, Shift, Busy, Done}), 32'd0);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);

        @(posedge Clk);
        #2 sw = 8'hC5; bop = 8'hC5; Reset_Load_Clear = 1'b1; Run = 1'b1;
        lds = 0;
        repeat (3) begin
            @(negedge Clk);
            #1;
            if (Ld_B && Clr_XA) lds++;
            chk("load_busy", 32'(Busy), 32'd0);
        end
        @(posedge Clk);
        #2 Reset_Load_Clear = 1'b0; Run = 1'b0;
        chk("load_count", 32'(lds), 32'd3);
        @(negedge Clk);
        #1 chk("load_no_start", 32'({Busy, Ld_B}), 32'd0);

        do_mult(40, 1'b0, 8'h45, 8'h80, 17'h1FE63);
        load(8'h03);
        do_mult(20, 1'b1, 8'h03, 8'h00, 17'h00015);
        load(8'h00);
        do_mult(20, 1'b0, 8'h00, 8'h00, 17'h00000);

        @(posedge Clk);
        #2 Run = 1'b1;
        @(posedge Clk);
        repeat (8) @(negedge Clk);
        #1 chk("in_add3", 32'(Busy), 32'd1);
        Reset_n = 1'b0; Run = 1'b0;
        #1 chk("async_rst", 32'({Ld_B, Clr_XA, Add, Sub, Shift, Busy, Done}), 32'd0);
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        #1 chk("post_rst_idle", 32'({Busy, Done}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
